warp_dispatcher: RTL and testbench

Sits between warp_scheduler and the NUM_SIMD_CORES SIMD cores. Buffers kernel_t packets issued on valid_kernel and dispatches each one to an idle core. Collects per-core done pulses and returns them to the scheduler one per cycle on finished_warp_id, using round-robin arbitration. Owns the core busy/free bookkeeping; warp_scheduler has no back-pressure input, so all buffering lives here.

---
 rtl/warp_dispatcher_pkg.sv | 44 ++++
 rtl/warp_dispatcher_fifo.sv | 69 ++++++
 rtl/warp_dispatcher.sv | 130 +++++++++++++
 tb/tb_warp_dispatcher.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_dispatcher_pkg.sv
// Shared types, constants and a rotating priority picker for the warp dispatch path.
package warp_dispatcher_pkg;

  localparam int NUM_SIMD_CORES      = 4;
  localparam int CORE_IDX_W          = (NUM_SIMD_CORES > 1) ? $clog2(NUM_SIMD_CORES) : 1;
  localparam int WARP_ID_W           = 4;
  localparam int DISPATCH_FIFO_DEPTH = 4;

  // Idle marker on finished_warp_id; the scheduler never issues this id.
  localparam logic [WARP_ID_W-1:0] NO_WARP = 4'hF;

  // Kernel packet issued by warp_scheduler. The dispatcher only looks at
  // warp_id; every other field travels to the core untouched.
  typedef struct packed {
    logic [WARP_ID_W-1:0] warp_id;
    logic [31:0]          start_pc;
    logic [15:0]          thread_mask;
    logic [7:0]           num_regs;
  } kernel_t;

  // Result of a priority search over the cores.
  typedef struct packed {
    logic                  found;
    logic [CORE_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req, searching upward from start and wrapping around.
  // start = 0 gives a plain lowest-index pick.
  function automatic pick_t pick_from(input logic [NUM_SIMD_CORES-1:0] req,
                                      input logic [CORE_IDX_W-1:0]     start);
    pick_t res;
    int    pos;
    logic  hit;
    res = '0;
    for (int i = 0; i < NUM_SIMD_CORES; i++) begin
      pos       = (int'(start) + i) % NUM_SIMD_CORES;
      hit       = req[pos] && !res.found;
      res.idx   = hit ? pos[CORE_IDX_W-1:0] : res.idx;
      res.found = res.found | req[pos];
    end
    return res;
  endfunction

endpackage

// File: rtl/warp_dispatcher_fifo.sv
// Synchronous kernel buffer. A pop in the same cycle frees a slot for a push,
// so a full buffer still accepts a kernel while it drains one.
module kernel_fifo
  import warp_dispatcher_pkg::*;
#(
  parameter  int DEPTH = DISPATCH_FIFO_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  kernel_t          din,
  input  logic             pop,
  output kernel_t          dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  kernel_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_next;

  assign dout = mem[rd_ptr];

  // Qualify requests against occupancy and work out the next fill level.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Pointers, fill level and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= PTR_W'(0);
      rd_ptr <= PTR_W'(0);
      count  <= CNT_W'(0);
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == CNT_W'(0));
    end
  end

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/warp_dispatcher.sv
// Buffers kernels from warp_scheduler, hands each to the lowest free SIMD core,
// and returns completed warp ids one per cycle through a round-robin arbiter.
module warp_dispatcher
  import warp_dispatcher_pkg::*;
#(
  parameter int FIFO_DEPTH = DISPATCH_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_kernel,
  input  kernel_t                          kernel_in,
  output logic    [NUM_SIMD_CORES-1:0]     core_start,
  output kernel_t [NUM_SIMD_CORES-1:0]     core_kernel,
  input  logic    [NUM_SIMD_CORES-1:0]     core_done,
  output logic    [WARP_ID_W-1:0]          finished_warp_id,
  output logic    [NUM_SIMD_CORES-1:0]     busy_mask,
  output logic                             fifo_full,
  output logic                             overflow,
  output logic                             all_idle
);

  localparam int FIFO_CNT_W = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  // Per-core bookkeeping: busy = running, pend = finished but not yet reported.
  logic [NUM_SIMD_CORES-1:0] busy;
  logic [NUM_SIMD_CORES-1:0] pend;
  logic [CORE_IDX_W-1:0]     ptr;

  logic [NUM_SIMD_CORES-1:0] free;
  logic [NUM_SIMD_CORES-1:0] done_cap;
  logic [NUM_SIMD_CORES-1:0] disp_hot;
  logic [NUM_SIMD_CORES-1:0] rep_hot;
  logic [NUM_SIMD_CORES-1:0] busy_next;
  logic [NUM_SIMD_CORES-1:0] pend_next;
  logic [CORE_IDX_W-1:0]     ptr_next;
  logic [WARP_ID_W-1:0]      fin_next;
  pick_t                     disp_pick;
  pick_t                     rep_pick;
  logic                      fifo_pop;
  logic                      drop;

  kernel_t                   fifo_dout;
  logic                      fifo_empty;
  logic [FIFO_CNT_W-1:0]     fifo_count;

  kernel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid_kernel),
    .din   (kernel_in),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Dispatch choice, done capture and report arbitration for this cycle.
  always_comb begin
    free      = ~(busy | pend);
    disp_pick = pick_from(free, CORE_IDX_W'(0));
    fifo_pop  = !fifo_empty && disp_pick.found;
    // The buffer takes the kernel unless it is full and nothing drains this cycle.
    drop      = valid_kernel && fifo_full && !fifo_pop;
    // A done pulse from an idle core carries no meaning and is discarded.
    done_cap  = core_done & busy;
    rep_pick  = pick_from(pend, ptr);

    disp_hot = {NUM_SIMD_CORES{1'b0}};
    rep_hot  = {NUM_SIMD_CORES{1'b0}};
    for (int c = 0; c < NUM_SIMD_CORES; c++) begin
      disp_hot[c] = fifo_pop && (disp_pick.idx == CORE_IDX_W'(c));
      rep_hot[c]  = rep_pick.found && (rep_pick.idx == CORE_IDX_W'(c));
    end

    // Dispatch targets free cores and done targets busy ones, so the set and
    // clear terms below never touch the same bit.
    busy_next = (busy & ~done_cap) | disp_hot;
    pend_next = (pend | done_cap) & ~rep_hot;

    if (rep_pick.found) begin
      // The core keeps its latched kernel until reported, so warp_id is still valid.
      fin_next = core_kernel[rep_pick.idx].warp_id;
      ptr_next = (rep_pick.idx == CORE_IDX_W'(NUM_SIMD_CORES - 1)) ?
                 CORE_IDX_W'(0) : rep_pick.idx + CORE_IDX_W'(1);
    end else begin
      fin_next = NO_WARP;
      ptr_next = ptr;
    end
  end

  // Core state, arbiter pointer and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy             <= {NUM_SIMD_CORES{1'b0}};
      pend             <= {NUM_SIMD_CORES{1'b0}};
      ptr              <= CORE_IDX_W'(0);
      core_start       <= {NUM_SIMD_CORES{1'b0}};
      finished_warp_id <= NO_WARP;
      busy_mask        <= {NUM_SIMD_CORES{1'b0}};
      overflow         <= 1'b0;
    end else begin
      busy             <= busy_next;
      pend             <= pend_next;
      ptr              <= ptr_next;
      core_start       <= disp_hot;
      finished_warp_id <= fin_next;
      busy_mask        <= busy_next | pend_next;
      overflow         <= overflow | drop;
    end
  end

  // Latch the popped kernel into the chosen core; it stays put while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_kernel <= '0;
    end else begin
      for (int c = 0; c < NUM_SIMD_CORES; c++) begin
        if (disp_hot[c]) begin
          core_kernel[c] <= fifo_dout;
        end
      end
    end
  end

  assign all_idle = (fifo_count == FIFO_CNT_W'(0)) && (busy_mask == {NUM_SIMD_CORES{1'b0}});

endmodule

// File: tb/tb_warp_dispatcher.sv
// Self-checking bench for warp_dispatcher: a per-cycle vector table for the
// single-kernel path, hand-written sequences for fill/overflow, round-robin
// reporting and reset, and scoreboards for dispatched kernels and reports.
module tb_warp_dispatcher;
  import warp_dispatcher_pkg::*;

  localparam int N = NUM_SIMD_CORES;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_kernel;
  kernel_t              kernel_in;
  logic    [N-1:0]      core_start;
  kernel_t [N-1:0]      core_kernel;
  logic    [N-1:0]      core_done;
  logic [WARP_ID_W-1:0] finished_warp_id;
  logic    [N-1:0]      busy_mask;
  logic                 fifo_full;
  logic                 overflow;
  logic                 all_idle;

  always #5 clk = ~clk;

  warp_dispatcher dut (
    .clk              (clk),
    .rst              (rst),
    .valid_kernel     (valid_kernel),
    .kernel_in        (kernel_in),
    .core_start       (core_start),
    .core_kernel      (core_kernel),
    .core_done        (core_done),
    .finished_warp_id (finished_warp_id),
    .busy_mask        (busy_mask),
    .fifo_full        (fifo_full),
    .overflow         (overflow),
    .all_idle         (all_idle)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int      core;
    kernel_t k;
  } disp_exp_t;

  disp_exp_t            disp_q[$];
  logic [WARP_ID_W-1:0] fin_q[$];

  typedef struct {
    logic                 v;
    logic [WARP_ID_W-1:0] warp;
    logic [31:0]          pc;
    logic [N-1:0]         done;
    logic [WARP_ID_W-1:0] rep;      // id expected to be reported for this done, NO_WARP if none
    logic [N-1:0]         e_start;
    logic [WARP_ID_W-1:0] e_fin;
    logic [N-1:0]         e_busy;
    logic                 e_idle;
  } vec_t;

  function automatic kernel_t mk(input int w, input logic [31:0] pc);
    kernel_t k;
    k             = '0;
    k.warp_id     = w[WARP_ID_W-1:0];
    k.start_pc    = pc;
    k.thread_mask = 16'hFFFF ^ pc[15:0];
    k.num_regs    = 8'(w + 3);
    return k;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every start pulse and every report against the scoreboards.
  task automatic monitor();
    disp_exp_t d;
    if (mon_en) begin
      for (int c = 0; c < N; c++) begin
        if (core_start[c] === 1'b1) begin
          if (disp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: core %0d started warp %0d, expected no start at %0t",
                     c, core_kernel[c].warp_id, $time);
          end else begin
            d = disp_q.pop_front();
            check("start_core", 64'(c), 64'(d.core));
            check("start_kernel", 64'(core_kernel[c]), 64'(d.k));
          end
        end
      end
      if (finished_warp_id !== NO_WARP) begin
        if (fin_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_report: got warp %0h, expected 0x%0h at %0t",
                   finished_warp_id, NO_WARP, $time);
        end else begin
          check("report_id", 64'(finished_warp_id), 64'(fin_q.pop_front()));
        end
      end
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, observe mid-cycle.
  task automatic cycle(input logic r, input logic v, input kernel_t k, input logic [N-1:0] d);
    @(posedge clk);
    #1;
    rst          = r;
    valid_kernel = v;
    kernel_in    = k;
    core_done    = d;
    @(negedge clk);
    monitor();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[9];
    kernel_t      k;
    logic [N-1:0] exp_s;

    rst          = 1'b1;
    valid_kernel = 1'b0;
    kernel_in    = '0;
    core_done    = '0;

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, '0);
    mon_en = 1'b1;

    // Quiet period straight out of reset.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, '0, '0);
      check("idle_fin", 64'(finished_warp_id), 64'(NO_WARP));
      check("idle_busy", 64'(busy_mask), 64'd0);
      check("idle_all_idle", 64'(all_idle), 64'd1);
      check("idle_start", 64'(core_start), 64'd0);
    end

    // Single kernel: start two cycles after issue, report two cycles after done.
    tbl[0] = '{1'b1, 4'd2, 32'hFFFF_FFFE, 4'b0000, NO_WARP, 4'b0000, NO_WARP, 4'b0000, 1'b1};
    tbl[1] = '{1'b0, 4'd0, 32'h0,         4'b0000, NO_WARP, 4'b0000, NO_WARP, 4'b0000, 1'b0};
    tbl[2] = '{1'b0, 4'd0, 32'h0,         4'b0000, NO_WARP, 4'b0001, NO_WARP, 4'b0001, 1'b0};
    tbl[3] = '{1'b0, 4'd0, 32'h0,         4'b0000, NO_WARP, 4'b0000, NO_WARP, 4'b0001, 1'b0};
    tbl[4] = '{1'b0, 4'd0, 32'h0,         4'b0000, NO_WARP, 4'b0000, NO_WARP, 4'b0001, 1'b0};
    tbl[5] = '{1'b0, 4'd0, 32'h0,         4'b0001, 4'd2,    4'b0000, NO_WARP, 4'b0001, 1'b0};
    tbl[6] = '{1'b0, 4'd0, 32'h0,         4'b0000, NO_WARP, 4'b0000, NO_WARP, 4'b0001, 1'b0};
    tbl[7] = '{1'b0, 4'd0, 32'h0,         4'b0000, NO_WARP, 4'b0000, 4'd2,    4'b0000, 1'b1};
    tbl[8] = '{1'b0, 4'd0, 32'h0,         4'b0000, NO_WARP, 4'b0000, NO_WARP, 4'b0000, 1'b1};
    for (int i = 0; i < 9; i++) begin
      k = tbl[i].v ? mk(int'(tbl[i].warp), tbl[i].pc) : '0;
      if (tbl[i].v) disp_q.push_back('{0, k});
      if (tbl[i].done != '0) fin_q.push_back(tbl[i].rep);
      cycle(1'b0, tbl[i].v, k, tbl[i].done);
      check("tbl_start", 64'(core_start), 64'(tbl[i].e_start));
      check("tbl_fin", 64'(finished_warp_id), 64'(tbl[i].e_fin));
      check("tbl_busy", 64'(busy_mask), 64'(tbl[i].e_busy));
      check("tbl_all_idle", 64'(all_idle), 64'(tbl[i].e_idle));
      if (tbl[i].e_start[0]) check("tbl_start_pc", 64'(core_kernel[0].start_pc), 64'hFFFF_FFFE);
    end
    check("tbl_sb_drained", 64'(disp_q.size() + fin_q.size()), 64'd0);

    // Fresh reset so the report pointer starts at core 0.
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0);

    // Nine kernels back to back: four start, four fill the buffer, the ninth drops.
    for (int i = 0; i < 9; i++) begin
      k = mk(i, 32'h1000 + 32'(i * 16));
      if (i < 4)       disp_q.push_back('{i, k});
      else if (i == 4) disp_q.push_back('{1, k});
      else if (i == 5) disp_q.push_back('{3, k});
      else if (i < 8)  disp_q.push_back('{-1, k});
      cycle(1'b0, 1'b1, k, '0);
      if (i >= 2 && i <= 5) begin
        exp_s        = '0;
        exp_s[i - 2] = 1'b1;
        check("fill_start_order", 64'(core_start), 64'(exp_s));
      end
      if (i == 6) check("fill_busy_all", 64'(busy_mask), 64'hF);
      if (i == 8) begin
        check("fill_full", 64'(fifo_full), 64'd1);
        check("fill_no_overflow_yet", 64'(overflow), 64'd0);
      end
    end
    cycle(1'b0, 1'b0, '0, '0);
    check("overflow_set", 64'(overflow), 64'd1);
    check("overflow_full", 64'(fifo_full), 64'd1);
    check("overflow_busy", 64'(busy_mask), 64'hF);
    cycle(1'b0, 1'b0, '0, '0);

    // Cores 1 and 3 finish together; reports go out lowest-first from pointer 0.
    fin_q.push_back(4'd1);
    fin_q.push_back(4'd3);
    cycle(1'b0, 1'b0, '0, 4'b1010);
    cycle(1'b0, 1'b0, '0, '0);
    check("rr_pend_busy", 64'(busy_mask), 64'hF);
    check("rr_no_report_yet", 64'(finished_warp_id), 64'(NO_WARP));
    cycle(1'b0, 1'b0, '0, '0);
    check("rr_first", 64'(finished_warp_id), 64'd1);
    check("rr_first_no_start", 64'(core_start), 64'd0);
    cycle(1'b0, 1'b0, '0, '0);
    check("rr_second", 64'(finished_warp_id), 64'd3);
    check("rr_core1_restart", 64'(core_start), 64'b0010);
    check("rr_core1_warp", 64'(core_kernel[1].warp_id), 64'd4);
    check("rr_not_full", 64'(fifo_full), 64'd0);
    cycle(1'b0, 1'b0, '0, '0);
    check("rr_done_reporting", 64'(finished_warp_id), 64'(NO_WARP));
    check("rr_core3_restart", 64'(core_start), 64'b1000);
    check("rr_core3_warp", 64'(core_kernel[3].warp_id), 64'd5);
    check("rr_queue_left", 64'(disp_q.size()), 64'd2);

    // Reset with cores busy and two kernels still buffered.
    cycle(1'b1, 1'b0, '0, '0);
    disp_q.delete();
    fin_q.delete();
    cycle(1'b0, 1'b0, '0, '0);
    check("rst_start", 64'(core_start), 64'd0);
    for (int c = 0; c < N; c++) check("rst_core_kernel", 64'(core_kernel[c]), 64'd0);
    check("rst_fin", 64'(finished_warp_id), 64'(NO_WARP));
    check("rst_busy", 64'(busy_mask), 64'd0);
    check("rst_full", 64'(fifo_full), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_all_idle", 64'(all_idle), 64'd1);
    cycle(1'b0, 1'b0, '0, 4'b1111);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, '0, '0);
      check("post_rst_fin", 64'(finished_warp_id), 64'(NO_WARP));
      check("post_rst_busy", 64'(busy_mask), 64'd0);
      check("post_rst_all_idle", 64'(all_idle), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
